// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake and flush.
// Define PIPE_REG_SKID_EN to add a skid entry and a registered in_ready.
module pipe_stage_reg #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             main_v_q, main_v_d;
    logic [WIDTH-1:0] main_d_q, main_d_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             accept;
    logic             fire;

    assign out_valid = main_v_q;
    assign out_data  = main_d_q;
    assign stall_cnt = stall_q;
    assign accept    = in_valid && in_ready;
    assign fire      = out_valid && out_ready;

`ifdef PIPE_REG_SKID_EN
    logic             skid_v_q, skid_v_d;
    logic [WIDTH-1:0] skid_d_q, skid_d_d;

    // Ready comes from registers only; the skid entry absorbs the
    // in-flight beat when out_ready falls.
    assign in_ready  = !skid_v_q && !flush;
    assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};

    always_comb begin
        main_v_d = main_v_q;
        main_d_d = main_d_q;
        skid_v_d = skid_v_q;
        skid_d_d = skid_d_q;
        if (flush) begin
            main_v_d = 1'b0;
            main_d_d = '0;
            skid_v_d = 1'b0;
            skid_d_d = '0;
        end else if (!main_v_q) begin
            if (accept) begin
                main_v_d = 1'b1;
                main_d_d = in_data;
            end
        end else if (fire) begin
            if (skid_v_q) begin
                main_d_d = skid_d_q;
                skid_v_d = 1'b0;
            end else if (accept) begin
                main_d_d = in_data;
            end else begin
                main_v_d = 1'b0;
            end
        end else if (accept) begin
            skid_v_d = 1'b1;
            skid_d_d = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            skid_v_q <= 1'b0;
            skid_d_q <= '0;
        end else begin
            skid_v_q <= skid_v_d;
            skid_d_q <= skid_d_d;
        end
    end
`else
    assign in_ready  = (!main_v_q || out_ready) && !flush;
    assign occupancy = {1'b0, main_v_q};

    always_comb begin
        main_v_d = main_v_q;
        main_d_d = main_d_q;
        if (flush) begin
            main_v_d = 1'b0;
            main_d_d = '0;
        end else if (accept) begin
            main_v_d = 1'b1;
            main_d_d = in_data;
        end else if (fire) begin
            main_v_d = 1'b0;
        end
    end
`endif

    // Flush does not clear the counter; only reset does.
    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && !flush && stall_q != CNT_MAX) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_v_q <= 1'b0;
            main_d_q <= '0;
            stall_q  <= '0;
        end else begin
            main_v_q <= main_v_d;
            main_d_q <= main_d_d;
            stall_q  <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed table-driven bench for pipe_stage_reg (both build modes),
// plus a CNT_W=2 instance for stall counter saturation.
module tb_pipe_stage_reg;

    typedef struct {
        logic       r;
        logic       f;
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       e_irdy;
        logic       e_ov;
        logic [7:0] e_od;
        logic [1:0] e_occ;
        logic [15:0] e_sc;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;

    logic        flush2;
    logic        in_valid2;
    logic        in_ready2;
    logic [7:0]  in_data2;
    logic        out_valid2;
    logic        out_ready2;
    logic [7:0]  out_data2;
    logic [1:0]  occupancy2;
    logic [1:0]  stall_cnt2;

    int n_chk;
    int n_fail;
    vec_t vq[$];

    pipe_stage_reg #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .flush(flush2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_data(out_data2), .occupancy(occupancy2),
        .stall_cnt(stall_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input int i, input vec_t v);
        reset     = v.r;
        flush     = v.f;
        in_valid  = v.iv;
        in_data   = v.id;
        out_ready = v.ordy;
        #1;
        chk($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(v.e_irdy));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(v.e_ov));
        chk($sformatf("v%0d out_data", i), 64'(out_data), 64'(v.e_od));
        chk($sformatf("v%0d occupancy", i), 64'(occupancy), 64'(v.e_occ));
        chk($sformatf("v%0d stall_cnt", i), 64'(stall_cnt), 64'(v.e_sc));
        @(negedge clk);
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        reset      = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        flush2     = 1'b0;
        in_valid2  = 1'b0;
        in_data2   = '0;
        out_ready2 = 1'b0;

        //                r  f  iv id     rdy irdy ov od     occ sc
        vq.push_back('{0, 0, 1, 8'h01, 1, 1, 1, 8'h01, 1, 0});
        vq.push_back('{0, 0, 1, 8'h02, 1, 1, 1, 8'h02, 1, 0});
        vq.push_back('{0, 0, 1, 8'h03, 1, 1, 1, 8'h03, 1, 0});
        vq.push_back('{0, 0, 0, 8'h00, 1, 1, 0, 8'h03, 0, 0});
        vq.push_back('{0, 0, 1, 8'h0A, 0, 1, 1, 8'h0A, 1, 0});
`ifdef PIPE_REG_SKID_EN
        vq.push_back('{0, 0, 1, 8'h0B, 0, 1, 1, 8'h0A, 2, 1});
        vq.push_back('{0, 0, 1, 8'h0C, 0, 0, 1, 8'h0A, 2, 2});
        vq.push_back('{0, 0, 1, 8'h0C, 1, 0, 1, 8'h0B, 1, 2});
        vq.push_back('{0, 0, 1, 8'h0C, 1, 1, 1, 8'h0C, 1, 2});
        vq.push_back('{0, 0, 0, 8'h00, 0, 1, 1, 8'h0C, 1, 3});
        vq.push_back('{0, 0, 1, 8'h55, 0, 1, 1, 8'h0C, 2, 4});
        vq.push_back('{0, 1, 1, 8'h66, 0, 0, 0, 8'h00, 0, 4});
        vq.push_back('{0, 0, 1, 8'h11, 0, 1, 1, 8'h11, 1, 4});
`else
        vq.push_back('{0, 0, 1, 8'h0B, 0, 0, 1, 8'h0A, 1, 1});
        vq.push_back('{0, 0, 1, 8'h0B, 0, 0, 1, 8'h0A, 1, 2});
        vq.push_back('{0, 0, 1, 8'h0B, 1, 1, 1, 8'h0B, 1, 2});
        vq.push_back('{0, 0, 1, 8'h0C, 1, 1, 1, 8'h0C, 1, 2});
        vq.push_back('{0, 0, 0, 8'h00, 0, 0, 1, 8'h0C, 1, 3});
        vq.push_back('{0, 1, 1, 8'h55, 0, 0, 0, 8'h00, 0, 3});
        vq.push_back('{0, 0, 1, 8'h11, 0, 1, 1, 8'h11, 1, 3});
`endif
        vq.push_back('{1, 1, 1, 8'h22, 0, 0, 0, 8'h00, 0, 0});
        vq.push_back('{0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0});
        vq.push_back('{0, 0, 1, 8'h33, 1, 1, 1, 8'h33, 1, 0});
        vq.push_back('{0, 1, 1, 8'h44, 1, 0, 0, 8'h00, 0, 0});

        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_data", 64'(out_data), 64'd0);
        chk("rst occupancy", 64'(occupancy), 64'd0);
        chk("rst stall_cnt", 64'(stall_cnt), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        foreach (vq[i]) apply(i, vq[i]);

        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Saturation of a 2-bit stall counter over 6 stalled cycles.
        in_valid2 = 1'b1;
        in_data2  = 8'h5A;
        @(posedge clk);
        #1;
        chk("sat load valid", 64'(out_valid2), 64'd1);
        chk("sat load cnt", 64'(stall_cnt2), 64'd0);
        @(negedge clk);
        in_valid2 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("sat cnt%0d", k), 64'(stall_cnt2),
                (k < 3) ? 64'(k) : 64'd3);
        end
        chk("sat data held", 64'(out_data2), 64'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
